udp_rx_server: RTL and testbench



---
 rtl/udp_rx_server_if.sv | 31 +++
 rtl/udp_rx_server.sv | 172 +++++++++++++++++
 tb/tb_udp_rx_server.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_rx_server_if.sv
// Bundles the IP-layer notification, RX DPRAM read port, outbound FIFO write port
// and receive status of udp_rx_server. master = the server, slave = its environment.
interface udp_rx_server_if;
  logic        newDatagram;
  logic [7:0]  protocolIn;
  logic [15:0] datagramSize;
  logic [31:0] sourceIP;
  logic        rdRAM;
  logic [10:0] rdAddr;
  logic [7:0]  rdData;
  logic        outstream_fifofull;
  logic        outstream_wren;
  logic [7:0]  outstream_wrdata;
  logic        rx_done;
  logic        rx_drop;
  logic [15:0] rx_srcPort;
  logic [31:0] rx_srcIP;
  logic [15:0] rx_payloadLen;

  modport master (
    input  newDatagram, protocolIn, datagramSize, sourceIP, rdData, outstream_fifofull,
    output rdRAM, rdAddr, outstream_wren, outstream_wrdata,
           rx_done, rx_drop, rx_srcPort, rx_srcIP, rx_payloadLen
  );

  modport slave (
    output newDatagram, protocolIn, datagramSize, sourceIP, rdData, outstream_fifofull,
    input  rdRAM, rdAddr, outstream_wren, outstream_wrdata,
           rx_done, rx_drop, rx_srcPort, rx_srcIP, rx_payloadLen
  );
endinterface

// File: rtl/udp_rx_server.sv
// UDP receive server: validates the UDP header in the RX DPRAM and streams accepted payload
// into the outbound FIFO. Define UDP_RX_SRCFILTER_EN to also require the expected peer IP/port.
module udp_rx_server #(
  parameter logic [15:0] DEVICE_UDP_PORT = 16'hbed0,
  parameter logic [31:0] DEST_IP         = 32'h0a0105ce,
  parameter logic [15:0] DEST_UDP_PORT   = 16'h1b3b,
  parameter logic [10:0] UDP_BASE        = 11'h022
) (
  input  logic             clk,
  input  logic             reset_n,
  udp_rx_server_if.master  bus
);

  typedef enum logic [2:0] {IDLE, HDR, CHECK, PAYLOAD, DRAIN, DONE} state_e;

  // Longest UDP length whose payload still fits above UDP_BASE without wrapping
  localparam logic [15:0] LEN_MAX = 16'(2048 - int'(UDP_BASE));

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        drop_q, drop_d;
  logic [15:0] size_q, size_d;
  logic [31:0] ip_q, ip_d;
  logic [15:0] src_port_q, src_port_d;
  logic [15:0] dst_port_q, dst_port_d;
  logic [15:0] len_q, len_d;
  logic        wren_q, wren_d;
  logic [15:0] rx_src_port_q, rx_src_port_d;
  logic [31:0] rx_src_ip_q, rx_src_ip_d;
  logic [15:0] rx_payload_len_q, rx_payload_len_d;

  logic        rd_ram;
  logic [10:0] rd_addr;
  logic        rx_done;
  logic        rx_drop;
  logic        src_reject;
  logic        reject;

`ifdef UDP_RX_SRCFILTER_EN
  assign src_reject = (ip_q != DEST_IP) || (src_port_q != DEST_UDP_PORT);
`else
  logic unused_src_cfg;
  assign src_reject     = 1'b0;
  assign unused_src_cfg = ^{DEST_IP, DEST_UDP_PORT};
`endif

  assign reject = (dst_port_q != DEVICE_UDP_PORT) || (len_q < 16'd8) ||
                  (len_q > size_q) || (len_q > LEN_MAX) || src_reject;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    drop_d           = drop_q;
    size_d           = size_q;
    ip_d             = ip_q;
    src_port_d       = src_port_q;
    dst_port_d       = dst_port_q;
    len_d            = len_q;
    wren_d           = 1'b0;
    rx_src_port_d    = rx_src_port_q;
    rx_src_ip_d      = rx_src_ip_q;
    rx_payload_len_d = rx_payload_len_q;
    rd_ram           = 1'b0;
    rd_addr          = '0;
    rx_done          = 1'b0;
    rx_drop          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.newDatagram) begin
          if (bus.protocolIn != 8'h11) begin
            drop_d  = 1'b1;
            state_d = DONE;
          end else begin
            size_d  = bus.datagramSize;
            ip_d    = bus.sourceIP;
            cnt_d   = '0;
            state_d = HDR;
          end
        end
      end
      HDR: begin
        // cnt 0..7 issue reads; cnt 1..8 capture the byte read one cycle earlier
        if (cnt_q < 16'd8) begin
          rd_ram  = 1'b1;
          rd_addr = UDP_BASE + cnt_q[10:0];
        end
        case (cnt_q)
          16'd1:   src_port_d[15:8] = bus.rdData;
          16'd2:   src_port_d[7:0]  = bus.rdData;
          16'd3:   dst_port_d[15:8] = bus.rdData;
          16'd4:   dst_port_d[7:0]  = bus.rdData;
          16'd5:   len_d[15:8]      = bus.rdData;
          16'd6:   len_d[7:0]       = bus.rdData;
          default: ;
        endcase
        if (cnt_q == 16'd8) state_d = CHECK;
        else                cnt_d   = cnt_q + 16'd1;
      end
      CHECK: begin
        if (reject) begin
          drop_d  = 1'b1;
          state_d = DONE;
        end else begin
          rx_src_port_d    = src_port_q;
          rx_src_ip_d      = ip_q;
          rx_payload_len_d = len_q - 16'd8;
          cnt_d            = '0;
          state_d          = (len_q == 16'd8) ? DONE : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (!bus.outstream_fifofull) begin
          rd_ram  = 1'b1;
          rd_addr = UDP_BASE + 11'd8 + cnt_q[10:0];
          wren_d  = 1'b1;
          if (cnt_q == len_q - 16'd9) state_d = DRAIN;
          else                        cnt_d   = cnt_q + 16'd1;
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        rx_done = 1'b1;
        rx_drop = drop_q;
        drop_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      drop_q           <= 1'b0;
      size_q           <= '0;
      ip_q             <= '0;
      src_port_q       <= '0;
      dst_port_q       <= '0;
      len_q            <= '0;
      wren_q           <= 1'b0;
      rx_src_port_q    <= '0;
      rx_src_ip_q      <= '0;
      rx_payload_len_q <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      drop_q           <= drop_d;
      size_q           <= size_d;
      ip_q             <= ip_d;
      src_port_q       <= src_port_d;
      dst_port_q       <= dst_port_d;
      len_q            <= len_d;
      wren_q           <= wren_d;
      rx_src_port_q    <= rx_src_port_d;
      rx_src_ip_q      <= rx_src_ip_d;
      rx_payload_len_q <= rx_payload_len_d;
    end
  end

  assign bus.rdRAM            = rd_ram;
  assign bus.rdAddr           = rd_addr;
  assign bus.outstream_wren   = wren_q;
  assign bus.outstream_wrdata = wren_q ? bus.rdData : '0;
  assign bus.rx_done          = rx_done;
  assign bus.rx_drop          = rx_drop;
  assign bus.rx_srcPort       = rx_src_port_q;
  assign bus.rx_srcIP         = rx_src_ip_q;
  assign bus.rx_payloadLen    = rx_payload_len_q;

endmodule

// File: tb/tb_udp_rx_server.sv
// Testbench for udp_rx_server: directed table, random datagrams against a reference model,
// plus a mid-payload reset sequence.
module tb_udp_rx_server;
  localparam logic [10:0] UDP_BASE   = 11'h022;
  localparam logic [15:0] LOCAL_PORT = 16'hbed0;
  localparam logic [31:0] PEER_IP    = 32'h0a0105ce;
  localparam logic [15:0] PEER_PORT  = 16'h1b3b;
`ifdef UDP_RX_SRCFILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  udp_rx_server_if bus();

  udp_rx_server #(
    .DEVICE_UDP_PORT(LOCAL_PORT),
    .DEST_IP(PEER_IP),
    .DEST_UDP_PORT(PEER_PORT),
    .UDP_BASE(UDP_BASE)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [7:0]  proto;
    logic [15:0] dst;
    logic [15:0] len;
    logic [15:0] size;
    logic [31:0] ip;
    int          mode;
    bit          dbf;
    bit          spur;
    bit          exp_drop;
    int          exp_wr;
  } vec_t;

  logic [7:0] mem [2048];
  int n_cmp = 0, n_err = 0;
  int cyc = 0, ff_mode = 0, ff_ph = 0, start_cyc = 0;
  int done_cnt = 0, done_cyc = 0, rd_cnt = 0, ff_viol = 0, lone_drop = 0;
  bit drop_at_done = 1'b0;
  logic [7:0] wr_q[$];
  int         wr_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference acceptance rule taken straight from the datagram fields
  function automatic bit model_accept(input logic [7:0] proto, input logic [15:0] dst,
                                      input logic [15:0] len, input logic [15:0] size,
                                      input logic [31:0] ip, input logic [15:0] src);
    if (proto != 8'h11) return 1'b0;
    if (dst != LOCAL_PORT) return 1'b0;
    if (len < 16'd8 || len > size || int'(len) > 2048 - 34) return 1'b0;
    if (FILT && (ip != PEER_IP || src != PEER_PORT)) return 1'b0;
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // RX DPRAM: data for a read issued in one cycle is presented during the next
  initial begin
    logic        rd_en;
    logic [10:0] rd_a;
    bus.rdData = '0;
    forever begin
      @(posedge clk);
      rd_en = bus.rdRAM;
      rd_a  = bus.rdAddr;
      #1;
      if (rd_en) bus.rdData = mem[rd_a];
      else       bus.rdData = 8'($urandom);
    end
  end

  initial begin
    bus.outstream_fifofull = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ff_mode)
        0:       bus.outstream_fifofull = 1'b0;
        1:       bus.outstream_fifofull = ($urandom_range(0, 2) == 0);
        default: begin
          bus.outstream_fifofull = (ff_ph % 8) < 3;
          ff_ph++;
        end
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus.outstream_wren) begin
      wr_q.push_back(bus.outstream_wrdata);
      wr_cyc.push_back(cyc);
    end
    if (bus.rdRAM) begin
      rd_cnt++;
      if (bus.outstream_fifofull && bus.rdAddr >= UDP_BASE + 11'd8) ff_viol++;
    end
    if (bus.rx_done) begin
      done_cnt++;
      done_cyc     = cyc;
      drop_at_done = bus.rx_drop;
    end
    if (bus.rx_drop && !bus.rx_done) lone_drop++;
  end

  task automatic check_zero(input string tag);
    check({tag, "/rdRAM"},         64'(bus.rdRAM), 64'd0);
    check({tag, "/rdAddr"},        64'(bus.rdAddr), 64'd0);
    check({tag, "/wren"},          64'(bus.outstream_wren), 64'd0);
    check({tag, "/wrdata"},        64'(bus.outstream_wrdata), 64'd0);
    check({tag, "/rx_done"},       64'(bus.rx_done), 64'd0);
    check({tag, "/rx_drop"},       64'(bus.rx_drop), 64'd0);
    check({tag, "/rx_srcPort"},    64'(bus.rx_srcPort), 64'd0);
    check({tag, "/rx_srcIP"},      64'(bus.rx_srcIP), 64'd0);
    check({tag, "/rx_payloadLen"}, 64'(bus.rx_payloadLen), 64'd0);
  endtask

  task automatic load(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                      input bit dbf);
    logic [10:0] a;
    mem[UDP_BASE]         = src[15:8];
    mem[UDP_BASE + 11'd1] = src[7:0];
    mem[UDP_BASE + 11'd2] = dst[15:8];
    mem[UDP_BASE + 11'd3] = dst[7:0];
    mem[UDP_BASE + 11'd4] = len[15:8];
    mem[UDP_BASE + 11'd5] = len[7:0];
    mem[UDP_BASE + 11'd6] = 8'($urandom);
    mem[UDP_BASE + 11'd7] = 8'($urandom);
    for (int i = 0; i < int'(len) - 8 && 42 + i < 2048; i++) begin
      a = UDP_BASE + 11'(8 + i);
      mem[a] = 8'($urandom);
    end
    if (dbf) begin
      mem[UDP_BASE + 11'd8]  = 8'hDE;
      mem[UDP_BASE + 11'd9]  = 8'hAD;
      mem[UDP_BASE + 11'd10] = 8'hBE;
      mem[UDP_BASE + 11'd11] = 8'hEF;
    end
  endtask

  task automatic pulse(input logic [7:0] proto, input logic [15:0] size, input logic [31:0] ip);
    @(posedge clk);
    #1;
    bus.protocolIn   = proto;
    bus.datagramSize = size;
    bus.sourceIP     = ip;
    bus.newDatagram  = 1'b1;
    start_cyc        = cyc;
    @(posedge clk);
    #1;
    bus.newDatagram = 1'b0;
  endtask

  task automatic run_dgram(input vec_t v, input logic [15:0] src, input string tag);
    int rd0, done0, viol0, lone0, bad, exp_rd, i;
    logic [10:0] a;
    load(src, v.dst, v.len, v.dbf);
    wr_q.delete();
    wr_cyc.delete();
    ff_mode = v.mode;
    rd0 = rd_cnt; done0 = done_cnt; viol0 = ff_viol; lone0 = lone_drop;
    pulse(v.proto, v.size, v.ip);
    for (i = 0; i < 8000; i++) begin
      if (done_cnt != done0) break;
      @(posedge clk);
      #1;
      bus.newDatagram = v.spur && (i % 37 == 5) && (i < 600);
    end
    bus.newDatagram = 1'b0;
    check({tag, "/done_in_time"}, 64'(i < 8000), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    ff_mode = 0;
    check({tag, "/done_pulses"}, 64'(done_cnt - done0), 64'd1);
    check({tag, "/drop"},        64'(drop_at_done), 64'(v.exp_drop));
    check({tag, "/lone_drop"},   64'(lone_drop - lone0), 64'd0);
    check({tag, "/writes"},      64'(wr_q.size()), 64'(v.exp_wr));
    bad = 0;
    for (int k = 0; k < wr_q.size() && 42 + k < 2048; k++) begin
      a = UDP_BASE + 11'(8 + k);
      if (wr_q[k] !== mem[a]) bad++;
    end
    check({tag, "/bad_bytes"}, 64'(bad), 64'd0);
    exp_rd = (v.proto != 8'h11) ? 0 : (v.exp_drop ? 8 : int'(v.len));
    check({tag, "/reads"},     64'(rd_cnt - rd0), 64'(exp_rd));
    check({tag, "/ff_respect"}, 64'(ff_viol - viol0), 64'd0);
    if (!v.exp_drop) begin
      check({tag, "/payloadLen"}, 64'(bus.rx_payloadLen), 64'(v.exp_wr));
      check({tag, "/srcPort"},    64'(bus.rx_srcPort), 64'(src));
      check({tag, "/srcIP"},      64'(bus.rx_srcIP), 64'(v.ip));
    end
    if (v.proto != 8'h11) check({tag, "/done_latency"}, 64'(done_cyc - start_cyc), 64'd1);
    if (v.dbf && v.exp_wr == 4 && wr_q.size() == 4) begin
      check({tag, "/bytes"}, 64'({wr_q[0], wr_q[1], wr_q[2], wr_q[3]}), 64'h00000000DEADBEEF);
      check({tag, "/back_to_back"}, 64'(wr_cyc[3] - wr_cyc[0]), 64'd3);
    end
  endtask

  initial begin
    vec_t tbl[12];
    vec_t v;
    int wr0, done0, i;

    tbl[0]  = '{8'h11, 16'hbed0, 16'd12,   16'd12,   PEER_IP, 0, 1'b1, 1'b0, 1'b0, 4};
    tbl[1]  = '{8'h11, 16'h1234, 16'd12,   16'd12,   PEER_IP, 0, 1'b0, 1'b0, 1'b1, 0};
    tbl[2]  = '{8'h06, 16'hbed0, 16'd12,   16'd12,   PEER_IP, 0, 1'b0, 1'b0, 1'b1, 0};
    tbl[3]  = '{8'h11, 16'hbed0, 16'd8,    16'd8,    PEER_IP, 0, 1'b0, 1'b0, 1'b0, 0};
    tbl[4]  = '{8'h11, 16'hbed0, 16'd7,    16'd7,    PEER_IP, 0, 1'b0, 1'b0, 1'b1, 0};
    tbl[5]  = '{8'h11, 16'hbed0, 16'd20,   16'd19,   PEER_IP, 0, 1'b0, 1'b0, 1'b1, 0};
    tbl[6]  = '{8'h11, 16'hbed0, 16'd20,   16'd20,   PEER_IP, 1, 1'b0, 1'b0, 1'b0, 12};
    tbl[7]  = '{8'h11, 16'hbed0, 16'd2015, 16'd2100, PEER_IP, 0, 1'b0, 1'b0, 1'b1, 0};
    tbl[8]  = '{8'h11, 16'hbed0, 16'd2014, 16'd2014, PEER_IP, 1, 1'b0, 1'b0, 1'b0, 2006};
    tbl[9]  = '{8'h11, 16'hbed0, 16'd1000, 16'd1000, PEER_IP, 2, 1'b0, 1'b1, 1'b0, 992};
    tbl[10] = '{8'h11, 16'hbed0, 16'd12,   16'd12,   32'h0a0105cf, 0, 1'b0, 1'b0, FILT, FILT ? 0 : 4};
    tbl[11] = '{8'h11, 16'hbed0, 16'd30,   16'd60,   PEER_IP, 0, 1'b0, 1'b0, 1'b0, 22};

    bus.newDatagram  = 1'b0;
    bus.protocolIn   = '0;
    bus.datagramSize = '0;
    bus.sourceIP     = '0;
    for (int k = 0; k < 2048; k++) mem[k] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset_n = 1'b1;

    for (int t = 0; t < 12; t++) run_dgram(tbl[t], PEER_PORT, $sformatf("tbl%0d", t));

    // Reset in the middle of a payload transfer
    load(PEER_PORT, LOCAL_PORT, 16'd200, 1'b0);
    wr_q.delete();
    pulse(8'h11, 16'd200, PEER_IP);
    for (i = 0; i < 500 && wr_q.size() < 10; i++) @(posedge clk);
    check("midrst/reached_payload", 64'(wr_q.size() >= 10), 64'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    done0 = done_cnt;
    @(posedge clk);
    #1;
    check_zero("midrst");
    wr0 = wr_q.size();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("midrst/no_writes", 64'(wr_q.size() - wr0), 64'd0);
    check("midrst/no_done", 64'(done_cnt - done0), 64'd0);
    run_dgram(tbl[0], PEER_PORT, "after_rst");

    for (int r = 0; r < 30; r++) begin
      logic [15:0] src;
      v.proto = ($urandom_range(0, 9) == 0) ? 8'h06 : 8'h11;
      v.dst   = ($urandom_range(0, 5) == 0) ? 16'($urandom) : LOCAL_PORT;
      v.len   = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 12))
                                            : 16'($urandom_range(8, 80));
      v.size  = ($urandom_range(0, 5) == 0) ? v.len - 16'd1
                                            : v.len + 16'($urandom_range(0, 4));
      v.ip    = ($urandom_range(0, 5) == 0) ? $urandom : PEER_IP;
      src     = ($urandom_range(0, 5) == 0) ? 16'($urandom) : PEER_PORT;
      v.mode  = int'($urandom_range(0, 2));
      v.dbf   = 1'b0;
      v.spur  = 1'b0;
      v.exp_drop = !model_accept(v.proto, v.dst, v.len, v.size, v.ip, src);
      v.exp_wr   = v.exp_drop ? 0 : int'(v.len) - 8;
      run_dgram(v, src, $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
